wb_spi_controller: RTL and testbench

- Wishbone peripheral that acts as an SPI controller, mode 0, MSB first, 8-bit frames.
- It is the opposite end of the existing SPI-peripheral-to-Wishbone-controller bridge. The host-side SPI bridge is a Wishbone controller; this block is a Wishbone peripheral that drives its own SPI bus.
- Connects to the top-level address decoder exactly like any other peripheral (stb gated per slot, dat/ack muxed back).
- Typical use: on-board flash or sensor access from the fabric.

---
 rtl/wb_spi_pkg.sv | 21 ++
 rtl/wb_spi_controller_if.sv | 21 ++
 rtl/spi_shift_engine.sv | 99 +++++++++
 rtl/wb_spi_controller.sv | 119 +++++++++++
 tb/tb_wb_spi_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_spi_pkg.sv
// Shared constants and types for the Wishbone SPI controller.
package wb_spi_pkg;

    // Register map, decoded from wb_adr[1:0]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLKDIV = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_RX_VALID = 1;
    localparam int unsigned STAT_OVERRUN  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } spi_state_e;

endpackage

// File: rtl/wb_spi_controller_if.sv
// Classic single-cycle Wishbone bus between the address decoder and the SPI controller.
interface wb_spi_controller_if #(
    parameter int pAddrLen = 4
) ();
    logic                wb_stb;
    logic                wb_we;
    logic [pAddrLen-1:0] wb_adr;
    logic [7:0]          wb_dat_i;
    logic [7:0]          wb_dat_o;
    logic                wb_ack;

    modport master (
        output wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode 0 shift engine: 8-bit MSB-first frames, half-period of (div+1) clocks.
module spi_shift_engine
    import wb_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic [7:0] div_i,
    input  logic       spi_sdi_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       spi_sck_o,
    output logic       spi_sdo_o
);

    spi_state_e state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sck_q, sck_d;
    logic       sdo_q, sdo_d;

    // State register; reset mid-frame aborts without a completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sck_q     <= sck_d;
            sdo_q     <= sdo_d;
        end
    end

    // Next-state: a phase ends when div_cnt reaches zero, then div is reloaded
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sck_d     = sck_q;
        sdo_d     = sdo_q;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d   = tx_byte_i;
                    sdo_d     = tx_byte_i[7];
                    bit_cnt_d = 3'd0;
                    div_cnt_d = div_i;
                    state_d   = LO;
                end
            end
            LO: begin
                if (div_cnt_q == 8'd0) begin
                    sck_d     = 1'b1;
                    shift_d   = {shift_q[6:0], spi_sdi_i};
                    div_cnt_d = div_i;
                    state_d   = HI;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            HI: begin
                if (div_cnt_q == 8'd0) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // After the shift, the next bit to send sits in the MSB
                        sdo_d     = shift_q[7];
                        div_cnt_d = div_i;
                        state_d   = LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign rx_byte_o = shift_q;
    assign spi_sck_o = sck_q;
    assign spi_sdo_o = sdo_q;

endmodule

// File: rtl/wb_spi_controller.sv
// Wishbone peripheral driving an SPI bus: register file, bus decode and status flags.
module wb_spi_controller
    import wb_spi_pkg::*;
#(
    parameter int         pAddrLen  = 4,
    parameter logic [7:0] pDivReset = 8'd3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    wb_spi_controller_if.slave        wb,
    output logic                      spi_sck,
    output logic                      spi_csn,
    output logic                      spi_sdo,
    input  logic                      spi_sdi,
    output logic                      irq
);

    logic       ack_q, ack_d;
    logic [7:0] dat_o_q, dat_o_d;
    logic       csn_q, csn_d;
    logic [7:0] clkdiv_q, clkdiv_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;

    logic       access, adr_ok, wr, rd, start;
    logic [1:0] reg_adr;
    logic       busy, done;
    logic [7:0] rx_byte;

    // An access executes only on the first strobe cycle; ack blocks the next one
    assign access  = wb.wb_stb & ~ack_q;
    assign adr_ok  = (wb.wb_adr[pAddrLen-1:2] == '0);
    assign reg_adr = wb.wb_adr[1:0];
    assign wr      = access & wb.wb_we & adr_ok;
    assign rd      = access & ~wb.wb_we & adr_ok;
    assign start   = wr & (reg_adr == ADDR_DATA) & ~busy;

    spi_shift_engine u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .tx_byte_i (wb.wb_dat_i),
        .div_i     (clkdiv_q),
        .spi_sdi_i (spi_sdi),
        .busy_o    (busy),
        .done_o    (done),
        .rx_byte_o (rx_byte),
        .spi_sck_o (spi_sck),
        .spi_sdo_o (spi_sdo)
    );

    // Register file and bus response state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_o_q    <= '0;
            csn_q      <= 1'b1;
            clkdiv_q   <= pDivReset;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_o_q    <= dat_o_d;
            csn_q      <= csn_d;
            clkdiv_q   <= clkdiv_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Decode, read mux and flag updates; frame completion overrides a same-cycle DATA read
    always_comb begin
        ack_d      = access;
        dat_o_d    = '0;
        csn_d      = csn_q;
        clkdiv_d   = clkdiv_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (rd) begin
            case (reg_adr)
                ADDR_DATA:   dat_o_d = rx_data_q;
                ADDR_STATUS: begin
                    dat_o_d[STAT_BUSY]     = busy;
                    dat_o_d[STAT_RX_VALID] = rx_valid_q;
                    dat_o_d[STAT_OVERRUN]  = overrun_q;
                end
                ADDR_CTRL:   dat_o_d = {7'b0, csn_q};
                default:     dat_o_d = clkdiv_q;
            endcase
            if (reg_adr == ADDR_DATA) rx_valid_d = 1'b0;
        end

        if (wr) begin
            case (reg_adr)
                ADDR_DATA:   if (busy) overrun_d = 1'b1;
                ADDR_STATUS: overrun_d = 1'b0;
                ADDR_CTRL:   csn_d = wb.wb_dat_i[0];
                default:     clkdiv_d = wb.wb_dat_i;
            endcase
        end

        if (done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q) overrun_d = 1'b1;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_dat_o = dat_o_q;
    assign spi_csn     = csn_q;
    assign irq         = rx_valid_q;

endmodule

// File: tb/tb_wb_spi_controller.sv
// Directed bench for wb_spi_controller with a mode-0 SPI slave model.
module tb_wb_spi_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_spi_controller_if #(.pAddrLen(4)) bus ();

    logic spi_sck, spi_csn, spi_sdo, spi_sdi, irq;

    wb_spi_controller #(.pAddrLen(4), .pDivReset(8'd3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb      (bus),
        .spi_sck (spi_sck),
        .spi_csn (spi_csn),
        .spi_sdo (spi_sdo),
        .spi_sdi (spi_sdi),
        .irq     (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model: drives MSB first, shifts on sck fall; logs sdo at sck rise
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] sdo_log = 8'h00;
    int rise_cnt = 0;
    int fall_cnt = 0;
    time t_rise = 0, t_fall = 0, hi_len = 0, lo_len = 0, t_start = 0;
    assign spi_sdi = slave_tx[7];

    always @(posedge spi_sck) begin
        sdo_log = {sdo_log[6:0], spi_sdo};
        rise_cnt++;
        if (rise_cnt > 1) lo_len = $time - t_fall;
        t_rise = $time;
    end

    always @(negedge spi_sck) begin
        slave_tx = {slave_tx[6:0], 1'b0};
        fall_cnt++;
        hi_len = $time - t_rise;
        t_fall = $time;
    end

    // One Wishbone access; called and returns 1 time unit after a rising edge
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [7:0] wdat,
                           output logic [7:0] rdat, output logic acked, output logic ack_after);
        bus.wb_stb   = 1'b1;
        bus.wb_we    = we;
        bus.wb_adr   = adr;
        bus.wb_dat_i = wdat;
        @(posedge clk);
        t_start = $time;
        #1;
        acked = bus.wb_ack;
        rdat  = bus.wb_dat_o;
        bus.wb_stb = 1'b0;
        bus.wb_we  = 1'b0;
        @(posedge clk);
        #1;
        ack_after = bus.wb_ack;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [7:0] wdat);
        logic [7:0] d;
        logic a, a2;
        wb_xfer(1'b1, adr, wdat, d, a, a2);
    endtask

    task automatic wb_read_check(input string tag, input logic [3:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        logic a, a2;
        wb_xfer(1'b0, adr, 8'h00, d, a, a2);
        check_eq(tag, {23'd0, a, d}, {23'd0, 1'b1, exp});
    endtask

    task automatic start_frame(input logic [7:0] tx, input logic [7:0] slave_byte);
        slave_tx = slave_byte;
        rise_cnt = 0;
        fall_cnt = 0;
        sdo_log  = 8'h00;
        wb_write(4'h0, tx);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (fall_cnt < 8 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("frame_done", fall_cnt, 8);
    endtask

    initial begin
        logic [7:0] d;
        logic a, a2;
        int n;
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_adr   = '0;
        bus.wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_csn", spi_csn, 1);
        check_eq("rst_sck", spi_sck, 0);
        check_eq("rst_irq", irq, 0);
        wb_read_check("rst_data", 4'h0, 8'h00);
        wb_read_check("rst_status", 4'h1, 8'h00);
        wb_read_check("rst_ctrl", 4'h2, 8'h01);
        wb_read_check("rst_clkdiv", 4'h3, 8'h03);

        // Fastest clock: A5 out, 3C in
        wb_write(4'h2, 8'h00);
        check_eq("csn_low", spi_csn, 0);
        wb_write(4'h3, 8'h00);
        start_frame(8'hA5, 8'h3C);
        wait_frame();
        check_eq("a5_len", 32'((t_fall - t_start) / 10), 16);
        check_eq("a5_sdo", sdo_log, 8'hA5);
        wb_read_check("a5_status", 4'h1, 8'h02);
        check_eq("a5_irq", irq, 1);
        wb_read_check("a5_rx", 4'h0, 8'h3C);
        wb_read_check("a5_status_clr", 4'h1, 8'h00);
        check_eq("a5_irq_clr", irq, 0);
        check_eq("a5_rises", rise_cnt, 8);

        // CLKDIV=3: 4-clock phases, 64-clock frame
        wb_write(4'h3, 8'h03);
        start_frame(8'hFF, 8'h81);
        wait_frame();
        check_eq("ff_len", 32'((t_fall - t_start) / 10), 64);
        check_eq("ff_hi", 32'(hi_len / 10), 4);
        check_eq("ff_lo", 32'(lo_len / 10), 4);
        check_eq("ff_sdo", sdo_log, 8'hFF);
        wb_read_check("ff_rx", 4'h0, 8'h81);

        // Write while busy: discarded, flags overrun
        start_frame(8'h11, 8'h5A);
        wb_write(4'h0, 8'h22);
        wait_frame();
        check_eq("ovr_sdo", sdo_log, 8'h11);
        wb_read_check("ovr_status", 4'h1, 8'h06);
        wb_write(4'h1, 8'h00);
        wb_read_check("ovr_clr", 4'h1, 8'h02);
        wb_read_check("ovr_rx", 4'h0, 8'h5A);
        check_eq("ovr_rises", rise_cnt, 8);

        // Reset in mid-frame at bit 4
        start_frame(8'h96, 8'hF0);
        n = 0;
        while (rise_cnt < 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("abort_reached_bit4", rise_cnt, 5);
        rst_n = 1'b0;
        #1;
        check_eq("abort_sck", spi_sck, 0);
        check_eq("abort_csn", spi_csn, 1);
        check_eq("abort_irq", irq, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        wb_read_check("abort_status", 4'h1, 8'h00);
        wb_read_check("abort_clkdiv", 4'h3, 8'h03);
        start_frame(8'hC3, 8'h6E);
        wait_frame();
        check_eq("post_len", 32'((t_fall - t_start) / 10), 64);
        check_eq("post_sdo", sdo_log, 8'hC3);
        wb_read_check("post_rx", 4'h0, 8'h6E);

        // Out-of-range addresses: acked, read zero, writes ignored
        wb_xfer(1'b0, 4'h5, 8'h00, d, a, a2);
        check_eq("oor_ack", a, 1);
        check_eq("oor_data", d, 8'h00);
        check_eq("oor_ack_drop", a2, 0);
        rise_cnt = 0;
        wb_xfer(1'b1, 4'h4, 8'h55, d, a, a2);
        check_eq("oor_wr_ack", a, 1);
        wb_write(4'h6, 8'h00);
        wb_write(4'h7, 8'h09);
        repeat (10) @(posedge clk);
        #1;
        check_eq("oor_no_frame", rise_cnt, 0);
        wb_read_check("oor_ctrl", 4'h2, 8'h01);
        wb_read_check("oor_clkdiv", 4'h3, 8'h03);
        wb_read_check("oor_status", 4'h1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
